// File: rtl/compositor_pkg.sv
// compositor_pkg: shared opcodes, colour type, background modes
// and the background pattern generator for sprite_compositor.
package compositor_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int V_DISPLAY_DEF = 480;

  typedef logic [5:0] color_t;
  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_SOLID  = 2'b00;
  localparam opcode_t OP_SPRITE = 2'b01;
  localparam opcode_t OP_BG     = 2'b10;
  localparam opcode_t OP_AUTO   = 2'b11;

  typedef enum logic [3:0] {
    BG_SOLID     = 4'd0,
    BG_CHECK     = 4'd1,
    BG_CHECK_SW  = 4'd2,
    BG_SCROLL_XP = 4'd3,
    BG_SCROLL_XM = 4'd4,
    BG_SCROLL_YP = 4'd5,
    BG_SCROLL_YM = 4'd6,
    BG_DIAG_PP   = 4'd7,
    BG_DIAG_MP   = 4'd8,
    BG_DIAG_PM   = 4'd9,
    BG_DIAG_MM   = 4'd10
  } bg_mode_e;

  // a[0..2] select R,G,B high bits; b is shared low bit
  function automatic color_t pattern(
    input logic [2:0] a,
    input logic       b
  );
    return {a[0], b, a[1], b, a[2], b};
  endfunction

  function automatic color_t bg_color(
    input logic [3:0] mode,
    input logic [9:0] h,
    input logic [9:0] v,
    input logic [9:0] s,
    input color_t     solid
  );
    logic [9:0] xp, xm, yp, ym;
    color_t     c;
    xp = h + s;
    xm = h - s;
    yp = v + s;
    ym = v - s;
    case (mode)
      BG_CHECK:     c = pattern(h[7:5], v[1]);
      BG_CHECK_SW:  c = pattern(v[7:5], h[1]);
      BG_SCROLL_XP: c = pattern(xp[7:5], v[2]);
      BG_SCROLL_XM: c = pattern(xm[7:5], v[2]);
      BG_SCROLL_YP: c = pattern(yp[7:5], h[2]);
      BG_SCROLL_YM: c = pattern(ym[7:5], h[2]);
      BG_DIAG_PP:   c = pattern(yp[7:5], xp[2]);
      BG_DIAG_MP:   c = pattern(yp[7:5], xm[2]);
      BG_DIAG_PM:   c = pattern(ym[7:5], xp[2]);
      BG_DIAG_MM:   c = pattern(ym[7:5], xm[2]);
      default:      c = solid;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sprite_compositor_mover.sv
// sprite_mover: position/direction state of one bouncing sprite,
// hit test and ROM address for the current pixel.
module sprite_mover
  import compositor_pkg::*;
#(
  parameter int         SW    = 6,
  parameter int         BW    = 1,
  parameter int         H     = H_DISPLAY_DEF,
  parameter int         V     = V_DISPLAY_DEF,
  parameter logic [9:0] LEFT0 = 10'd100,
  parameter logic [9:0] TOP0  = 10'd100,
  parameter logic       DX0   = 1'b0,
  parameter logic       DY0   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               pause,
  input  logic               enable,
  input  logic [BW-1:0]      bank,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  output logic               hit,
  output logic [BW+2*SW-1:0] addr,
  output logic               bounced
);

  localparam logic [9:0] XMAX = 10'(H - (1 << SW) - 1);
  localparam logic [9:0] YMAX = 10'(V - (1 << SW) - 1);

  logic [9:0] left, top, rx, ry;
  logic       dx, dy, fx, fy, step;

  // dx/dy = 1 means moving towards larger coordinates
  assign fx = dx ? (left == XMAX) : (left == 10'd1);
  assign fy = dy ? (top == YMAX) : (top == 10'd1);
  assign step = tick & ~pause;
  assign bounced = step & (fx | fy);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      left <= LEFT0;
      top  <= TOP0;
      dx   <= DX0;
      dy   <= DY0;
    end else if (step) begin
      left <= dx ? left + 10'd1 : left - 10'd1;
      top  <= dy ? top + 10'd1 : top - 10'd1;
      if (fx) dx <= ~dx;
      if (fy) dy <= ~dy;
    end
  end

  assign rx = hpos - left;
  assign ry = vpos - top;
  assign hit = enable
             && (rx[9:SW] == '0)
             && (ry[9:SW] == '0);
  assign addr = {bank, ry[SW-1:0], rx[SW-1:0]};

endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: N bouncing sprites over a selectable background,
// 2-cycle pixel pipeline. Optional overlap flag: SPRITE_COLLISION_EN.
module sprite_compositor
  import compositor_pkg::*;
#(
  parameter int     N_SPRITES   = 2,
  parameter int     SPRITE_SIZE = 64,
  parameter int     N_BANKS     = 2,
  parameter int     H_DISPLAY   = H_DISPLAY_DEF,
  parameter int     V_DISPLAY   = V_DISPLAY_DEF,
  parameter color_t TRANS_KEY   = 6'h00,
  localparam int    SW = $clog2(SPRITE_SIZE),
  localparam int    BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
  localparam int    AW = BW + 2 * SW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [9:0]                hpos,
  input  logic [9:0]                vpos,
  input  logic                      visible,
  input  logic                      cmd_valid,
  input  logic [7:0]                cmd,
  output logic [N_SPRITES*AW-1:0]   rom_addr,
  input  logic [N_SPRITES*6-1:0]    rom_rgb,
  output color_t                    rgb,
  output logic                      collision
);

  logic [N_SPRITES-1:0]         en, hit_w, hit_q;
  logic [N_SPRITES-1:0]         bounced, opq;
  logic [N_SPRITES-1:0][BW-1:0] bank;
  logic [N_SPRITES*AW-1:0]      addr_w;
  color_t                       solid_color, bg_w, bg_q, pix;
  logic [3:0]                   bg_mode, bounce_cnt, eff_mode;
  logic                         auto_mode, pause, tick, vis_q;
  logic [9:0]                   vpos_q, scroll;
  logic                         op_solid, op_sprite, op_bg, op_auto;

  assign op_solid  = cmd[7:6] == OP_SOLID;
  assign op_sprite = cmd[7:6] == OP_SPRITE;
  assign op_bg     = cmd[7:6] == OP_BG;
  assign op_auto   = cmd[7:6] == OP_AUTO;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      solid_color <= 6'h3F;
      bg_mode     <= '0;
      auto_mode   <= 1'b0;
      pause       <= 1'b0;
      en          <= '1;
      bank        <= '0;
    end else if (cmd_valid) begin
      unique case (1'b1)
        op_solid: solid_color <= cmd[5:0];
        op_sprite: begin
          for (int i = 0; i < N_SPRITES; i++) begin
            if (cmd[5:4] == 2'(i)) begin
              en[i]   <= cmd[3];
              bank[i] <= cmd[BW-1:0];
            end
          end
        end
        op_bg: begin
          bg_mode   <= cmd[3:0];
          auto_mode <= 1'b0;
        end
        op_auto: begin
          auto_mode <= 1'b1;
          pause     <= cmd[0];
        end
        default: ;
      endcase
    end
  end

  // frame tick: first cycle after vpos returns to line 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vpos_q     <= '0;
      tick       <= 1'b0;
      scroll     <= '0;
      bounce_cnt <= '0;
    end else begin
      vpos_q <= vpos;
      tick   <= (vpos == '0) && (vpos_q != '0);
      if (tick && !pause) begin
        scroll <= scroll + 10'd1;
        if (|bounced) bounce_cnt <= bounce_cnt + 4'd1;
      end
    end
  end

  for (genvar i = 0; i < N_SPRITES; i++) begin : g_spr
    sprite_mover #(
      .SW    (SW),
      .BW    (BW),
      .H     (H_DISPLAY),
      .V     (V_DISPLAY),
      .LEFT0 (10'(100 + 80 * i)),
      .TOP0  (10'(100 + 40 * i)),
      .DX0   (1'(i % 2)),
      .DY0   (1'(i % 2))
    ) u_mover (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .pause   (pause),
      .enable  (en[i]),
      .bank    (bank[i]),
      .hpos    (hpos),
      .vpos    (vpos),
      .hit     (hit_w[i]),
      .addr    (addr_w[i*AW +: AW]),
      .bounced (bounced[i])
    );
  end

  assign eff_mode = auto_mode ? bounce_cnt : bg_mode;
  assign bg_w = bg_color(eff_mode, hpos, vpos,
                         scroll, solid_color);

  // S2: lowest index opaque sprite wins over background
  always_comb begin
    opq = '0;
    pix = bg_q;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (hit_q[i] && rom_rgb[i*6 +: 6] != TRANS_KEY) begin
        opq[i] = 1'b1;
        pix    = rom_rgb[i*6 +: 6];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr <= '0;
      hit_q    <= '0;
      vis_q    <= 1'b0;
      bg_q     <= '0;
      rgb      <= '0;
    end else begin
      rom_addr <= addr_w;
      hit_q    <= hit_w;
      vis_q    <= visible;
      bg_q     <= bg_w;
      rgb      <= vis_q ? pix : '0;
    end
  end

`ifdef SPRITE_COLLISION_EN
  localparam logic [N_SPRITES-1:0] ONE = 1;
  logic overlap;

  // more than one bit set in the opaque mask
  assign overlap = |(opq & (opq - ONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collision <= 1'b0;
    end else if (tick) begin
      collision <= 1'b0;
    end else if (overlap) begin
      collision <= 1'b1;
    end
  end
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed vector table plus motion, pause,
// collision and reset sequences against a small behavioural model.
`timescale 1ns/1ps
module tb_sprite_compositor;

  localparam int AW = 13;
`ifdef SPRITE_COLLISION_EN
  localparam logic COLL_EN = 1'b1;
`else
  localparam logic COLL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [9:0]      hpos = '0;
  logic [9:0]      vpos = '0;
  logic            visible = 1'b0;
  logic            cmd_valid = 1'b0;
  logic [7:0]      cmd = '0;
  logic [2*AW-1:0] rom_addr;
  logic [11:0]     rom_rgb;
  logic [5:0]      rgb;
  logic            collision;
  logic [5:0]      r0 = '0;
  logic [5:0]      r1 = '0;

  assign rom_rgb = {r1, r0};

  always #5 clk = ~clk;

  sprite_compositor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hpos      (hpos),
    .vpos      (vpos),
    .visible   (visible),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .rom_addr  (rom_addr),
    .rom_rgb   (rom_rgb),
    .rgb       (rgb),
    .collision (collision)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int         ml [2];
  int         mt [2];
  bit         mdx [2];
  bit         mdy [2];
  logic [3:0] mbc, mmode;
  logic [9:0] mscroll;
  logic [5:0] msolid;
  bit         mauto, mpause;

  typedef struct {
    string      name;
    int         h;
    int         v;
    bit         vis;
    logic [5:0] c0;
    logic [5:0] c1;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ml[0] = 100; mt[0] = 100; mdx[0] = 0; mdy[0] = 0;
    ml[1] = 180; mt[1] = 140; mdx[1] = 1; mdy[1] = 1;
    mbc = 0; mmode = 0; mscroll = 0; msolid = 6'h3F;
    mauto = 0; mpause = 0;
  endtask

  task automatic model_tick();
    bit any, fx, fy;
    any = 0;
    if (!mpause) begin
      for (int i = 0; i < 2; i++) begin
        fx = mdx[i] ? (ml[i] == 575) : (ml[i] == 1);
        fy = mdy[i] ? (mt[i] == 415) : (mt[i] == 1);
        ml[i] += mdx[i] ? 1 : -1;
        mt[i] += mdy[i] ? 1 : -1;
        if (fx) mdx[i] = !mdx[i];
        if (fy) mdy[i] = !mdy[i];
        any |= fx | fy;
      end
      mscroll++;
      if (any) mbc++;
    end
  endtask

  function automatic logic [5:0] pat(input logic [9:0] a,
                                     input logic b);
    return {a[5], b, a[6], b, a[7], b};
  endfunction

  function automatic logic [5:0] exp_bg(input logic [3:0] m,
                                        input logic [9:0] h,
                                        input logic [9:0] v);
    logic [9:0] xp, xm, yp, ym;
    xp = h + mscroll; xm = h - mscroll;
    yp = v + mscroll; ym = v - mscroll;
    case (m)
      4'd1:  return pat(h, v[1]);
      4'd2:  return pat(v, h[1]);
      4'd3:  return pat(xp, v[2]);
      4'd4:  return pat(xm, v[2]);
      4'd5:  return pat(yp, h[2]);
      4'd6:  return pat(ym, h[2]);
      4'd7:  return pat(yp, xp[2]);
      4'd8:  return pat(yp, xm[2]);
      4'd9:  return pat(ym, xp[2]);
      4'd10: return pat(ym, xm[2]);
      default: return msolid;
    endcase
  endfunction

  function automatic bit inside_spr(input int k, input int h,
                                    input int v);
    return h >= ml[k] && h < ml[k] + 64
        && v >= mt[k] && v < mt[k] + 64;
  endfunction

  function automatic logic [5:0] exp_pix(input int h, input int v);
    logic [5:0] c;
    c = exp_bg(mauto ? mbc : mmode, 10'(h), 10'(v));
    if (inside_spr(1, h, v) && r1 != 6'h00) c = r1;
    if (inside_spr(0, h, v) && r0 != 6'h00) c = r0;
    return c;
  endfunction

  task automatic probe(input int h, input int v, input bit vis,
                       output logic [5:0] got,
                       output logic [AW-1:0] a0);
    hpos = 10'(h);
    vpos = 10'(v);
    visible = vis;
    step();
    a0 = rom_addr[AW-1:0];
    step();
    got = rgb;
    visible = 1'b0;
  endtask

  task automatic chk_pix(input string nm, input int h, input int v,
                         input logic [5:0] exp);
    logic [5:0]    g;
    logic [AW-1:0] a;
    probe(h, v, 1'b1, g, a);
    check(nm, {26'd0, g}, {26'd0, exp});
  endtask

  task automatic send(input logic [7:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    case (c[7:6])
      2'b00: msolid = c[5:0];
      2'b10: begin mmode = c[3:0]; mauto = 0; end
      2'b11: begin mauto = 1; mpause = c[0]; end
      default: ;
    endcase
  endtask

  task automatic do_tick();
    hpos = '0;
    visible = 1'b0;
    vpos = 10'd1;
    step();
    vpos = '0;
    step();
    step();
    model_tick();
  endtask

  logic [5:0]    got;
  logic [AW-1:0] a0;
  int            t;
  bit            found;
  int            ox, oy;

  initial begin
    vecs[0]  = '{"bg_solid",    10,  10, 1, 6'h15, 6'h2A, 6'h3F};
    vecs[1]  = '{"invisible",   10,  10, 0, 6'h15, 6'h2A, 6'h00};
    vecs[2]  = '{"spr0_origin", 100, 100, 1, 6'h15, 6'h2A, 6'h15};
    vecs[3]  = '{"spr0_corner", 163, 163, 1, 6'h15, 6'h2A, 6'h15};
    vecs[4]  = '{"spr0_right",  164, 100, 1, 6'h15, 6'h2A, 6'h3F};
    vecs[5]  = '{"spr0_left",   99,  100, 1, 6'h15, 6'h2A, 6'h3F};
    vecs[6]  = '{"spr0_above",  100, 99,  1, 6'h15, 6'h2A, 6'h3F};
    vecs[7]  = '{"spr0_key",    100, 100, 1, 6'h00, 6'h2A, 6'h3F};
    vecs[8]  = '{"spr1_origin", 180, 140, 1, 6'h15, 6'h2A, 6'h2A};
    vecs[9]  = '{"spr1_corner", 243, 203, 1, 6'h15, 6'h2A, 6'h2A};
    vecs[10] = '{"spr1_right",  244, 203, 1, 6'h15, 6'h2A, 6'h3F};
    vecs[11] = '{"spr_invis",   100, 100, 0, 6'h15, 6'h2A, 6'h00};

    model_reset();
    rst_n = 1'b0;
    step();
    step();
    check("rst_rgb", {26'd0, rgb}, 32'h0);
    check("rst_addr", {6'd0, rom_addr}, 32'h0);
    check("rst_coll", {31'd0, collision}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      r0 = vecs[i].c0;
      r1 = vecs[i].c1;
      probe(vecs[i].h, vecs[i].v, vecs[i].vis, got, a0);
      check(vecs[i].name, {26'd0, got}, {26'd0, vecs[i].exp});
    end

    r0 = 6'h15;
    r1 = 6'h2A;
    probe(100, 100, 1'b1, got, a0);
    check("addr0_origin", {19'd0, a0}, 32'h0);

    send(8'h05);
    chk_pix("solid_cmd", 10, 10, 6'h05);
    send(8'h81);
    chk_pix("mode1", 32, 2, 6'h35);
    send(8'h82);
    chk_pix("mode2", 2, 96, 6'h3D);
    send(8'h8C);
    chk_pix("mode12_solid", 32, 2, 6'h05);
    send(8'h80);
    send(8'h40);
    chk_pix("spr0_disabled", 100, 100, 6'h05);
    send(8'h49);
    probe(101, 102, 1'b1, got, a0);
    check("spr0_bank1", {26'd0, got}, 32'h15);
    check("addr0_bank1", {19'd0, a0}, 32'h1081);
    send(8'h60);
    chk_pix("k2_ignored", 100, 100, 6'h15);
    send(8'h48);

    // motion: sprite 0 transparent so background shows through
    r0 = 6'h00;
    send(8'hC0);
    for (t = 1; t <= 99; t++) do_tick();
    chk_pix("bc_t99", 32, 2, 6'h05);
    do_tick();
    chk_pix("bc_once", 32, 2, 6'h35);
    for (t = 101; t <= 276; t++) do_tick();
    chk_pix("top_bounce", 456, 416, 6'h2A);
    chk_pix("top_above", 456, 415, 6'h02);
    do_tick();
    chk_pix("top_back", 457, 415, 6'h2A);
    chk_pix("top_back_c", 520, 478, 6'h2A);
    chk_pix("top_back_o", 521, 478, exp_pix(521, 478));

    found = 0;
    for (int k = 0; k < 2800 && !found; k++) begin
      do_tick();
      if (ml[0] - ml[1] < 64 && ml[1] - ml[0] < 64 &&
          mt[0] - mt[1] < 64 && mt[1] - mt[0] < 64)
        found = 1;
    end
    check("overlap_found", {31'd0, found}, 32'h1);
    if (found) begin
      ox = (ml[0] > ml[1]) ? ml[0] : ml[1];
      oy = (mt[0] > mt[1]) ? mt[0] : mt[1];
      r0 = 6'h15;
      chk_pix("prio_both", ox, oy, 6'h15);
      check("coll_set", {31'd0, collision}, {31'd0, COLL_EN});
      r0 = 6'h00;
      chk_pix("prio_key", ox, oy, 6'h2A);
      check("coll_hold", {31'd0, collision}, {31'd0, COLL_EN});
      do_tick();
      check("coll_clear", {31'd0, collision}, 32'h0);
    end

    send(8'hC1);
    for (int k = 0; k < 3; k++) do_tick();
    send(8'h87);
    chk_pix("pause_spr1", ml[1], mt[1], 6'h2A);
    for (int h = 100; h < 104; h++)
      chk_pix("pause_scroll", h, 50, exp_pix(h, 50));
    send(8'hC0);
    do_tick();
    send(8'h87);
    chk_pix("run_spr1", ml[1], mt[1], 6'h2A);
    for (int h = 100; h < 104; h++)
      chk_pix("run_scroll", h, 50, exp_pix(h, 50));

    // reset in the middle of a visible line
    r0 = 6'h15;
    hpos = 10'd100;
    vpos = 10'd100;
    visible = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    check("midrst_rgb", {26'd0, rgb}, 32'h0);
    check("midrst_coll", {31'd0, collision}, 32'h0);
    rst_n = 1'b1;
    model_reset();
    chk_pix("midrst_origin", 100, 100, 6'h15);
    chk_pix("midrst_solid", 10, 10, 6'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
